util_mw_dac_bridge_buf: RTL and testbench

UTIL_MW_DAC_BRIDGE_BUF -- requirements
Module: util_mw_dac_bridge_buf

---
 rtl/util_mw_dac_bridge_buf.sv | 167 ++++++++++++++++
 tb/tb_util_mw_dac_bridge_buf.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/util_mw_dac_bridge_buf.sv
`default_nettype none
// ============================================================================
// Module   : util_mw_dac_bridge_buf
// Purpose  : DMA-to-DAC bridge with a user-IP return FIFO and a bypass path.
// Revision : 1.0 - initial release
// ============================================================================
module util_mw_dac_bridge_buf #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CHAN   = 4,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CHAN-1:0]            dac_valid_in,
   input  logic [NUM_CHAN-1:0]            dac_enable,
   input  logic [DATA_WIDTH*NUM_CHAN-1:0] dmac_in,
   output logic                           bridge_enable_out,
   output logic                           bridge_valid_out,
   output logic [DATA_WIDTH*NUM_CHAN-1:0] bridge_out,
   input  logic                           bridge_valid_in,
   input  logic [DATA_WIDTH*NUM_CHAN-1:0] bridge_in,
   input  logic                           bypass,
   input  logic                           clear_status,
   output logic                           dac_valid,
   output logic [DATA_WIDTH*NUM_CHAN-1:0] dac_data,
   output logic [DEPTH_LOG2:0]            fill_level,
   output logic [1:0]                     state,
   output logic                           underflow,
   output logic                           overflow
);

   localparam int                  c_WORD_W  = DATA_WIDTH * NUM_CHAN;
   localparam int                  c_DEPTH_N = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_DEPTH   = (DEPTH_LOG2+1)'(c_DEPTH_N);
   localparam logic [DEPTH_LOG2:0] c_HALF    = (DEPTH_LOG2+1)'(c_DEPTH_N / 2);
   localparam logic [DEPTH_LOG2:0] c_FILL_ONE = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_FILL = 2'b01,
      S_RUN  = 2'b10
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_WORD_W-1:0]   r_mem [0:c_DEPTH_N-1];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_fill;
   logic [c_WORD_W-1:0]   r_dac_data;
   logic                  r_underflow;
   logic                  r_overflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_try;
   logic                  w_rd_try;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_underflow_ev;
   logic                  w_overflow_ev;
   logic [c_WORD_W-1:0]   w_load_src;
   logic [c_WORD_W-1:0]   w_load_data;

   assign bridge_enable_out = |dac_enable;
   assign bridge_valid_out  = |dac_valid_in;
   assign dac_valid         = |dac_valid_in;
   assign bridge_out        = dmac_in;

   assign w_full  = (r_fill == c_DEPTH);
   assign w_empty = (r_fill == '0);

   assign w_wr_try       = bridge_valid_in & ~bypass & (r_state != S_IDLE);
   assign w_rd_try       = dac_valid & ~bypass & (r_state == S_RUN);
   assign w_rd           = w_rd_try & ~w_empty;
   // A full FIFO still accepts a write when the head is popped on the same edge
   assign w_wr           = w_wr_try & (~w_full | w_rd);
   assign w_underflow_ev = w_rd_try & w_empty;
   assign w_overflow_ev  = w_wr_try & w_full & ~w_rd;

   assign w_load_src = bypass ? bridge_in : r_mem[r_rd_ptr];

   for (genvar n = 0; n < NUM_CHAN; n++) begin : g_lane
      assign w_load_data[n*DATA_WIDTH +: DATA_WIDTH] =
         dac_enable[n] ? w_load_src[n*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!bridge_enable_out || bypass) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_FILL;
            S_FILL:  if (r_fill >= c_HALF) w_state_nxt = S_RUN;
            S_RUN:   if (w_underflow_ev) w_state_nxt = S_FILL;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= bridge_in;
      end
   end

   // IDLE holds the FIFO flushed so every FILL starts from an empty buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else if (r_state == S_IDLE) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_rd) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_wr, w_rd})
            2'b10:   r_fill <= r_fill + c_FILL_ONE;
            2'b01:   r_fill <= r_fill - c_FILL_ONE;
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dac_data <= '0;
      end else if (bypass) begin
         if (bridge_valid_in) r_dac_data <= w_load_data;
      end else if (w_rd) begin
         r_dac_data <= w_load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_underflow_ev)    r_underflow <= 1'b1;
         else if (clear_status) r_underflow <= 1'b0;
         if (w_overflow_ev)     r_overflow  <= 1'b1;
         else if (clear_status) r_overflow  <= 1'b0;
      end
   end

   assign dac_data   = r_dac_data;
   assign fill_level = r_fill;
   assign state      = r_state;
   assign underflow  = r_underflow;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_util_mw_dac_bridge_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_util_mw_dac_bridge_buf
// Purpose  : Directed self-checking bench for util_mw_dac_bridge_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_util_mw_dac_bridge_buf;

   logic        clk;
   logic        rst;
   logic [3:0]  dac_valid_in;
   logic [3:0]  dac_enable;
   logic [63:0] dmac_in;
   logic        bridge_enable_out;
   logic        bridge_valid_out;
   logic [63:0] bridge_out;
   logic        bridge_valid_in;
   logic [63:0] bridge_in;
   logic        bypass;
   logic        clear_status;
   logic        dac_valid;
   logic [63:0] dac_data;
   logic [4:0]  fill_level;
   logic [1:0]  state;
   logic        underflow;
   logic        overflow;

   int tests;
   int fails;

   util_mw_dac_bridge_buf #(
      .DATA_WIDTH (16),
      .NUM_CHAN   (4),
      .DEPTH_LOG2 (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .dac_valid_in      (dac_valid_in),
      .dac_enable        (dac_enable),
      .dmac_in           (dmac_in),
      .bridge_enable_out (bridge_enable_out),
      .bridge_valid_out  (bridge_valid_out),
      .bridge_out        (bridge_out),
      .bridge_valid_in   (bridge_valid_in),
      .bridge_in         (bridge_in),
      .bypass            (bypass),
      .clear_status      (clear_status),
      .dac_valid         (dac_valid),
      .dac_data          (dac_data),
      .fill_level        (fill_level),
      .state             (state),
      .underflow         (underflow),
      .overflow          (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Distinct value per lane so lane swaps are visible
   function automatic logic [63:0] word(input int i);
      logic [15:0] v;
      v = 16'(i);
      return {v + 16'h0300, v + 16'h0200, v + 16'h0100, v};
   endfunction

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0;
      dac_valid_in = 4'b0010;
      dac_enable = 4'hF;
      dmac_in = 64'h1234_5678_9ABC_DEF0;
      bridge_valid_in = 1'b0;
      bridge_in = '0;
      bypass = 1'b0;
      clear_status = 1'b0;

      #1 rst = 1'b1;
      #1;
      check("rst_dac_data", dac_data, 64'h0);
      check("rst_fill", 64'(fill_level), 64'd0);
      check("rst_state", 64'(state), 64'd0);
      check("rst_flags", 64'({underflow, overflow}), 64'd0);
      check("comb_bridge_out", bridge_out, 64'h1234_5678_9ABC_DEF0);
      check("comb_valid", 64'({bridge_valid_out, dac_valid, bridge_enable_out}), 64'b111);

      tick();
      tick();
      rst = 1'b0;
      dac_valid_in = 4'b0000;
      check("dac_valid_low", 64'(dac_valid), 64'd0);
      tick();
      check("idle_to_fill", 64'(state), 64'd1);

      // Fill 8 words; FILL->RUN is decided on the edge after the 8th write
      for (int i = 1; i <= 8; i++) begin
         bridge_valid_in = 1'b1;
         bridge_in = word(i);
         tick();
      end
      bridge_valid_in = 1'b0;
      check("fill8_level", 64'(fill_level), 64'd8);
      check("fill8_state", 64'(state), 64'd1);
      tick();
      check("run_state", 64'(state), 64'd2);

      for (int i = 1; i <= 8; i++) begin
         dac_valid_in = 4'b0001;
         tick();
         check($sformatf("read_%0d", i), dac_data, word(i));
         dac_valid_in = 4'b0000;
         tick();
         check($sformatf("hold_%0d", i), dac_data, word(i));
      end
      check("drained_level", 64'(fill_level), 64'd0);

      // Underflow with a same-cycle write and clear_status
      dac_valid_in = 4'b1000;
      bridge_valid_in = 1'b1;
      bridge_in = word(99);
      clear_status = 1'b1;
      tick();
      check("uf_flag", 64'(underflow), 64'd1);
      check("uf_hold", dac_data, word(8));
      check("uf_state", 64'(state), 64'd1);
      check("uf_write_level", 64'(fill_level), 64'd1);
      dac_valid_in = 4'b0000;
      bridge_valid_in = 1'b0;
      tick();
      check("uf_cleared", 64'(underflow), 64'd0);
      clear_status = 1'b0;

      for (int i = 101; i <= 115; i++) begin
         bridge_valid_in = 1'b1;
         bridge_in = word(i);
         tick();
      end
      check("full_level", 64'(fill_level), 64'd16);
      check("full_state", 64'(state), 64'd2);
      bridge_in = word(116);
      tick();
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_level", 64'(fill_level), 64'd16);
      bridge_valid_in = 1'b0;
      clear_status = 1'b1;
      tick();
      check("ovf_cleared", 64'(overflow), 64'd0);
      clear_status = 1'b0;

      bridge_valid_in = 1'b1;
      bridge_in = word(117);
      dac_valid_in = 4'b0100;
      tick();
      check("rw_full_ovf", 64'(overflow), 64'd0);
      check("rw_full_level", 64'(fill_level), 64'd16);
      check("rw_full_data", dac_data, word(99));
      bridge_valid_in = 1'b0;

      for (int i = 101; i <= 116; i++) begin
         tick();
         check($sformatf("drain_%0d", i), dac_data, (i == 116) ? word(117) : word(i));
      end
      dac_valid_in = 4'b0000;
      check("drain_level", 64'(fill_level), 64'd0);
      check("drain_no_uf", 64'(underflow), 64'd0);

      for (int i = 200; i < 205; i++) begin
         bridge_valid_in = 1'b1;
         bridge_in = word(i);
         tick();
      end
      bridge_valid_in = 1'b0;
      check("pre_rst_level", 64'(fill_level), 64'd5);
      check("pre_rst_state", 64'(state), 64'd2);
      #3 rst = 1'b1;
      #1;
      check("async_rst_data", dac_data, 64'h0);
      check("async_rst_level", 64'(fill_level), 64'd0);
      check("async_rst_state", 64'(state), 64'd0);
      tick();
      rst = 1'b0;

      bypass = 1'b1;
      dac_enable = 4'b0101;
      bridge_valid_in = 1'b1;
      bridge_in = {4{16'hAAAA}};
      tick();
      check("byp_data", dac_data, 64'h0000_AAAA_0000_AAAA);
      check("byp_state", 64'(state), 64'd0);
      check("byp_level", 64'(fill_level), 64'd0);
      bridge_valid_in = 1'b0;
      bridge_in = {4{16'h5555}};
      tick();
      check("byp_hold", dac_data, 64'h0000_AAAA_0000_AAAA);
      bridge_valid_in = 1'b1;
      tick();
      check("byp_reload", dac_data, 64'h0000_5555_0000_5555);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
